// File: rtl/md_sequencer.sv
// md_sequencer
// ------------
// Multi-cycle multiply/divide sequencer owning the architectural HI/LO
// registers. A mult/multu/div/divu accepted from the E stage computes its
// result immediately into pending registers. A down-counter then models the
// unit latency, and the result is committed to HI/LO when the counter expires.
// mthi/mtlo write HI/LO directly at the next edge.
//
// Optional feature macro: MD_ZERO_SKIP_EN
//   When defined, a mult/multu with a zero operand, or a div/divu with a zero
//   divisor, commits at the acceptance edge and never raises BUSY.
//
// Parameters
//   MULT_CYCLES  BUSY cycles for mult/multu (>= 1)
//   DIV_CYCLES   BUSY cycles for div/divu   (>= 1)
//
// Ports
//   clk          pipeline clock
//   reset        asynchronous reset, active low
//   valid_E      E stage holds a real instruction
//   HILOOP       0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 none
//   ARI1_E       rs operand (dividend / mthi-mtlo data)
//   ARI2_E       rt operand (divisor)
//   HILOSel_E    read select: 01 HI, 10 LO, otherwise 0
//   md_use_D     D-stage instruction uses the mult/div unit or HI/LO
//   start        operation accepted this cycle (combinational)
//   BUSY         operation in progress (registered)
//   MDdata_E     committed HI/LO read value (combinational)
//   stall_md_D   D-stage stall request
//   HI, LO       architectural registers
//   dbg_state_o  current FSM state (1 = RUN)
//
// Handshake: an op is taken in a cycle where valid_E is high, HILOOP is
// 1..4 and BUSY is low. That cycle raises start. No back-pressure exists
// beyond BUSY, so the pipeline must hold off HI/LO users while stall_md_D
// is high.
module md_sequencer #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_E,
    input  logic [2:0]  HILOOP,
    input  logic [31:0] ARI1_E,
    input  logic [31:0] ARI2_E,
    input  logic [1:0]  HILOSel_E,
    input  logic        md_use_D,
    output logic        start,
    output logic        BUSY,
    output logic [31:0] MDdata_E,
    output logic        stall_md_D,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic        dbg_state_o
);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    localparam int MAX_N = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W = (MAX_N > 1) ? $clog2(MAX_N) : 1;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_e;

    state_e             state_q;
    logic               busy_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [31:0]        hi_q, lo_q;
    logic [31:0]        phi_q, plo_q;

    logic               is_md_op;
    logic               is_mult;
    logic               go;
    logic               zero_skip;
    logic [CNT_W-1:0]   cnt_load_d;
    logic [31:0]        res_hi_d, res_lo_d;

    logic signed [63:0] prod_s;
    logic [63:0]        prod_u;
    logic               div_zero;
    logic               div_ovf;
    logic [31:0]        divisor_safe;
    logic signed [31:0] quot_s, rem_s;
    logic [31:0]        quot_u, rem_u;

    assign is_md_op = (HILOOP == OP_MULT) || (HILOOP == OP_MULTU) ||
                      (HILOOP == OP_DIV)  || (HILOOP == OP_DIVU);
    assign is_mult  = (HILOOP == OP_MULT) || (HILOOP == OP_MULTU);
    assign go       = valid_E && is_md_op && !busy_q;

    assign start       = go;
    assign BUSY        = busy_q;
    assign stall_md_D  = md_use_D && (go || busy_q);
    assign HI          = hi_q;
    assign LO          = lo_q;
    assign dbg_state_o = (state_q == S_RUN);
    assign cnt_load_d  = is_mult ? CNT_W'(MULT_CYCLES - 1) : CNT_W'(DIV_CYCLES - 1);

    // Reads always see committed values; pending results stay hidden until commit.
    always_comb begin
        MDdata_E = 32'd0;
        case (HILOSel_E)
            2'b01:   MDdata_E = hi_q;
            2'b10:   MDdata_E = lo_q;
            default: MDdata_E = 32'd0;
        endcase
    end

`ifdef MD_ZERO_SKIP_EN
    assign zero_skip = is_mult ? ((ARI1_E == 32'd0) || (ARI2_E == 32'd0)) : div_zero;
`else
    assign zero_skip = 1'b0;
`endif

    // Result datapath. Divide-by-zero and the signed overflow case are
    // special-cased, and the divisor is forced to 1 there so the native
    // divide operator never sees an undefined operand.
    always_comb begin
        prod_s       = $signed({{32{ARI1_E[31]}}, ARI1_E}) * $signed({{32{ARI2_E[31]}}, ARI2_E});
        prod_u       = {32'd0, ARI1_E} * {32'd0, ARI2_E};
        div_zero     = (ARI2_E == 32'd0);
        div_ovf      = (ARI1_E == 32'h8000_0000) && (ARI2_E == 32'hFFFF_FFFF);
        divisor_safe = (div_zero || div_ovf) ? 32'd1 : ARI2_E;
        quot_s       = $signed(ARI1_E) / $signed(divisor_safe);
        rem_s        = $signed(ARI1_E) % $signed(divisor_safe);
        quot_u       = ARI1_E / divisor_safe;
        rem_u        = ARI1_E % divisor_safe;
        res_hi_d     = 32'd0;
        res_lo_d     = 32'd0;
        case (HILOOP)
            OP_MULT: begin
                res_hi_d = prod_s[63:32];
                res_lo_d = prod_s[31:0];
            end
            OP_MULTU: begin
                res_hi_d = prod_u[63:32];
                res_lo_d = prod_u[31:0];
            end
            OP_DIV: begin
                if (div_zero) begin
                    res_hi_d = ARI1_E;
                    res_lo_d = 32'hFFFF_FFFF;
                end else if (div_ovf) begin
                    res_hi_d = 32'd0;
                    res_lo_d = 32'h8000_0000;
                end else begin
                    res_hi_d = rem_s;
                    res_lo_d = quot_s;
                end
            end
            OP_DIVU: begin
                if (div_zero) begin
                    res_hi_d = ARI1_E;
                    res_lo_d = 32'hFFFF_FFFF;
                end else begin
                    res_hi_d = rem_u;
                    res_lo_d = quot_u;
                end
            end
            default: begin
                res_hi_d = 32'd0;
                res_lo_d = 32'd0;
            end
        endcase
    end

    // Sequencer FSM. The counter is loaded with N-1, so BUSY stays high for
    // exactly N cycles and the commit happens on the edge that leaves RUN.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            phi_q   <= 32'd0;
            plo_q   <= 32'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (go) begin
                        if (zero_skip) begin
                            hi_q <= res_hi_d;
                            lo_q <= res_lo_d;
                        end else begin
                            phi_q   <= res_hi_d;
                            plo_q   <= res_lo_d;
                            cnt_q   <= cnt_load_d;
                            busy_q  <= 1'b1;
                            state_q <= S_RUN;
                        end
                    end else if (valid_E && (HILOOP == OP_MTHI)) begin
                        hi_q <= ARI1_E;
                    end else if (valid_E && (HILOOP == OP_MTLO)) begin
                        lo_q <= ARI1_E;
                    end
                end
                S_RUN: begin
                    if (cnt_q == '0) begin
                        hi_q    <= phi_q;
                        lo_q    <= plo_q;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_md_sequencer.sv
module tb_md_sequencer;
  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic        clk;
  logic        reset;
  logic        valid_E;
  logic [2:0]  HILOOP;
  logic [31:0] ARI1_E, ARI2_E;
  logic [1:0]  HILOSel_E;
  logic        md_use_D;
  logic        start, BUSY, stall_md_D, dbg_state;
  logic [31:0] MDdata_E, HI, LO;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [31:0] exp_hi, exp_lo, pend_hi, pend_lo;
  int          busy_left;
  logic [31:0] exp_q[$];

  md_sequencer #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk(clk), .reset(reset), .valid_E(valid_E), .HILOOP(HILOOP),
    .ARI1_E(ARI1_E), .ARI2_E(ARI2_E), .HILOSel_E(HILOSel_E),
    .md_use_D(md_use_D), .start(start), .BUSY(BUSY), .MDdata_E(MDdata_E),
    .stall_md_D(stall_md_D), .HI(HI), .LO(LO), .dbg_state_o(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // {hi, lo} computed from the arithmetic definitions with 64-bit integers
  function automatic logic [63:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    longint sa, sb, p, q, r;
    longint unsigned ua, ub, pu;
    logic [63:0] res;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    res = 64'd0;
    case (op)
      3'd1: begin p = sa * sb; res = p; end
      3'd2: begin pu = ua * ub; res = pu; end
      3'd3: begin
        if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
        else begin
          q = sa / sb;
          r = sa - q * sb;
          res = {r[31:0], q[31:0]};
        end
      end
      3'd4: begin
        if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
        else begin
          pu = ua / ub;
          ua = ua % ub;
          res = {ua[31:0], pu[31:0]};
        end
      end
      default: res = 64'd0;
    endcase
    return res;
  endfunction

  function automatic bit ref_skip(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
`ifdef MD_ZERO_SKIP_EN
    if (op == 3'd1 || op == 3'd2) return (a == 0) || (b == 0);
    if (op == 3'd3 || op == 3'd4) return b == 0;
    return 1'b0;
`else
    return 1'b0;
`endif
  endfunction

  // driver: one full clock cycle with pre-edge checks and model update
  task automatic step(input logic v, input logic [2:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic [1:0] sel, input logic use_d);
    logic        e_busy, e_go;
    logic [31:0] e_md;
    logic [63:0] r;
    @(negedge clk);
    e_busy = (busy_left > 0);
    check("busy", BUSY, e_busy);
    check("state", dbg_state, e_busy);
    check("hi", HI, exp_hi);
    check("lo", LO, exp_lo);
    valid_E = v; HILOOP = op; ARI1_E = a; ARI2_E = b; HILOSel_E = sel; md_use_D = use_d;
    #1;
    e_go = v && (op >= 3'd1) && (op <= 3'd4) && !e_busy;
    e_md = (sel == 2'b01) ? exp_hi : (sel == 2'b10) ? exp_lo : 32'd0;
    check("start", start, e_go);
    check("stall", stall_md_D, use_d && (e_go || e_busy));
    check("mddata", MDdata_E, e_md);
    @(posedge clk);
    if (busy_left > 0) begin
      busy_left--;
      if (busy_left == 0) begin
        exp_hi = exp_q.pop_front();
        exp_lo = exp_q.pop_front();
      end
    end else if (e_go) begin
      r = ref_result(op, a, b);
      if (ref_skip(op, a, b)) begin
        exp_hi = r[63:32];
        exp_lo = r[31:0];
      end else begin
        exp_q.push_back(r[63:32]);
        exp_q.push_back(r[31:0]);
        busy_left = (op <= 3'd2) ? MULT_N : DIV_N;
      end
    end else if (v && op == 3'd5) begin
      exp_hi = a;
    end else if (v && op == 3'd6) begin
      exp_lo = a;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 3'd0, 32'd0, 32'd0, 2'b00, 1'b0);
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return $urandom_range(0, 20);
      4: return 32'd0 - $urandom_range(1, 20);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    reset = 1'b0; valid_E = 0; HILOOP = 0; ARI1_E = 0; ARI2_E = 0; HILOSel_E = 0; md_use_D = 0;
    exp_hi = 0; exp_lo = 0; busy_left = 0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_busy", BUSY, 1'b0);
    check("rst_hi", HI, 32'd0);
    check("rst_lo", LO, 32'd0);
    check("rst_start", start, 1'b0);
    check("rst_stall", stall_md_D, 1'b0);
    reset = 1'b1;

    // first op accepted on the first edge after reset release
    step(1'b1, 3'd1, 32'hFFFF_FFFE, 32'd3, 2'b00, 1'b1);
    idle(MULT_N);
    #1;
    check("mult_hi", HI, 32'hFFFF_FFFF);
    check("mult_lo", LO, 32'hFFFF_FFFA);
    check("mult_busy_drop", BUSY, 1'b0);

    // back-to-back multu, plus mult while busy and a mult with valid low
    step(1'b1, 3'd2, 32'hFFFF_FFFE, 32'd3, 2'b01, 1'b0);
    step(1'b1, 3'd1, 32'd100, 32'd100, 2'b10, 1'b1);
    step(1'b1, 3'd5, 32'hDEAD_BEEF, 32'd0, 2'b01, 1'b1);
    idle(MULT_N - 2);
    #1;
    check("multu_hi", HI, 32'd2);
    check("multu_lo", LO, 32'hFFFF_FFFA);
    step(1'b0, 3'd1, 32'd9, 32'd9, 2'b01, 1'b1);
    #1;
    check("novalid_hi", HI, 32'd2);

    // div -7/2 and divu 7/0
    step(1'b1, 3'd3, 32'hFFFF_FFF9, 32'd2, 2'b00, 1'b0);
    idle(DIV_N);
    #1;
    check("div_lo", LO, 32'hFFFF_FFFD);
    check("div_hi", HI, 32'hFFFF_FFFF);
    step(1'b1, 3'd4, 32'd7, 32'd0, 2'b00, 1'b0);
    idle(DIV_N);
    #1;
    check("divu0_lo", LO, 32'hFFFF_FFFF);
    check("divu0_hi", HI, 32'd7);
    step(1'b1, 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 2'b00, 1'b0);
    idle(DIV_N);
    #1;
    check("divovf_lo", LO, 32'h8000_0000);
    check("divovf_hi", HI, 32'd0);

    // mtlo then read LO next cycle
    step(1'b1, 3'd6, 32'h0000_1234, 32'd0, 2'b00, 1'b0);
    step(1'b0, 3'd0, 32'd0, 32'd0, 2'b10, 1'b0);
    check("mtlo_read", MDdata_E, 32'h0000_1234);

    // zero-operand mult
    step(1'b1, 3'd5, 32'h55, 32'd0, 2'b00, 1'b0);
    step(1'b1, 3'd1, 32'd0, 32'd5, 2'b00, 1'b1);
    #1;
`ifdef MD_ZERO_SKIP_EN
    check("zskip_busy", BUSY, 1'b0);
    check("zskip_hi", HI, 32'd0);
`else
    check("zfull_busy", BUSY, 1'b1);
    check("zfull_hi", HI, 32'h55);
`endif
    idle(MULT_N);

    // reset in the middle of a run
    step(1'b1, 3'd1, 32'h1234, 32'h5678, 2'b00, 1'b0);
    idle(1);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("midrst_busy", BUSY, 1'b0);
    check("midrst_hi", HI, 32'd0);
    check("midrst_lo", LO, 32'd0);
    exp_hi = 0; exp_lo = 0; busy_left = 0; exp_q.delete();
    @(negedge clk);
    reset = 1'b1;
    idle(MULT_N + 2);

    // randomized traffic
    for (int i = 0; i < 500; i++) begin
      logic [2:0] op;
      op = 3'($urandom_range(0, 7));
      step($urandom_range(0, 9) < 8, op, pick_operand(), pick_operand(),
           2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end
    idle(DIV_N + 1);
    @(negedge clk);
    check("end_hi", HI, exp_hi);
    check("end_lo", LO, exp_lo);
    check("end_busy", BUSY, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
